sp_ram_req_ctrl: RTL and testbench

- Request/response front-end that sits directly upstream of the 64x32 single-port SRAM wrapper. It drives the RAM's active-low CEN/WEN, address and write data, and consumes its read data.
- Converts a valid/ready request channel into single-cycle RAM strobes.
- Absorbs the RAM's fixed 1-cycle read latency with a 2-entry response FIFO, so that a stalled consumer never loses read data.

---
 rtl/sp_ram_req_ctrl_if.sv | 28 ++
 rtl/sp_ram_req_ctrl.sv | 146 ++++++++++++++
 tb/tb_sp_ram_req_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_req_ctrl_if.sv
// Request/response channel between a requester and sp_ram_req_ctrl.
// Request: valid/ready with write enable, word address and write data.
// Response: valid/ready carrying read data in request order.
interface sp_ram_req_ctrl_if #(
  parameter int unsigned ADR_BIT = 6,
  parameter int unsigned DAT_BIT = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADR_BIT-1:0] req_addr;
  logic [DAT_BIT-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DAT_BIT-1:0] rsp_rdata;

  // Requester / response consumer side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_ram_req_ctrl.sv
// sp_ram_req_ctrl: valid/ready front-end for a single-port SRAM with
// active-low CEN/WEN and a fixed 1-cycle read latency. Read data is
// captured into a 2-entry in-order response FIFO; request acceptance is
// throttled so that the FIFO can never overflow.
//
// Optional build macro SP_RAM_CLR_ON_RST_EN: after reset, sweep all RAM
// words to zero (init_busy=1, requests blocked) before entering normal
// operation. Without the macro init_busy is tied to 0.
module sp_ram_req_ctrl #(
  parameter int unsigned ADR_BIT = 6,
  parameter int unsigned DAT_BIT = 32
) (
  input  logic               clk,
  input  logic               rst,
  sp_ram_req_ctrl_if.slave   bus,
  output logic               init_busy,
  output logic               ram_cen,
  output logic               ram_wen,
  output logic [ADR_BIT-1:0] ram_addr,
  output logic [DAT_BIT-1:0] ram_wdata,
  input  logic [DAT_BIT-1:0] ram_rdata
);

  logic               fire;
  logic               pop;
  logic               push;
  logic               req_ready;
  logic [2:0]         occ;
  logic [1:0]         count_q, count_d;
  logic               inflight_q, inflight_d;
  logic               rd_ptr_q, wr_ptr_q;
  logic [DAT_BIT-1:0] fifo_q [2];

`ifdef SP_RAM_CLR_ON_RST_EN
  localparam int unsigned DEPTH = 2 ** ADR_BIT;
  localparam logic [ADR_BIT-1:0] LAST_ADDR = ADR_BIT'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [ADR_BIT-1:0] clr_addr_q, clr_addr_d;
  logic               init_busy_q, init_busy_d;

  // Clear-sweep state register; reset always restarts the sweep at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_addr_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Clear-sweep next state: one word per cycle, leave INIT after the last word
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_busy_d = init_busy_q;
    case (state_q)
      ST_INIT: begin
        clr_addr_d = clr_addr_q + ADR_BIT'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        init_busy_d = 1'b0;
      end
      default: begin
        state_d     = ST_INIT;
        clr_addr_d  = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

  // Handshake decode; pop feeds req_ready so a draining FIFO keeps full rate
  assign pop       = bus.rsp_valid & bus.rsp_ready;
  assign push      = inflight_q;
  assign occ       = {1'b0, count_q} + 3'(inflight_q) - 3'(pop);
  assign req_ready = ~init_busy & ~rst & (occ < 3'd2);
  assign fire      = bus.req_valid & req_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_rdata = fifo_q[rd_ptr_q];

  // RAM strobes: straight from fire, or the clear sweep when it is active
  always_comb begin
    ram_cen   = ~fire;
    ram_wen   = ~(fire & bus.req_we);
    ram_addr  = bus.req_addr;
    ram_wdata = bus.req_wdata;
`ifdef SP_RAM_CLR_ON_RST_EN
    if (init_busy_q && !rst) begin
      ram_cen   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = clr_addr_q;
      ram_wdata = '0;
    end
`endif
  end

  // Next occupancy and read-in-flight flag
  always_comb begin
    inflight_d = fire & ~bus.req_we;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Response FIFO storage and pointers; reset drops in-flight and queued data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Directed bench for sp_ram_req_ctrl with a behavioural 64x32 SRAM model
// (active-low CEN/WEN, read data valid the cycle after the strobe).
module tb_sp_ram_req_ctrl;
  localparam int unsigned ADR_BIT = 6;
  localparam int unsigned DAT_BIT = 32;
  localparam int unsigned DEPTH   = 2 ** ADR_BIT;

  logic               clk = 1'b0;
  logic               rst;
  logic               init_busy;
  logic               ram_cen, ram_wen;
  logic [ADR_BIT-1:0] ram_addr;
  logic [DAT_BIT-1:0] ram_wdata;
  logic [DAT_BIT-1:0] ram_rdata;
  logic [DAT_BIT-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  sp_ram_req_ctrl_if #(.ADR_BIT(ADR_BIT), .DAT_BIT(DAT_BIT)) bus ();

  sp_ram_req_ctrl #(.ADR_BIT(ADR_BIT), .DAT_BIT(DAT_BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_busy (init_busy),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) mem[ram_addr] <= ram_wdata;
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input int addr, input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = ADR_BIT'(addr);
    bus.req_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 32'h0);
    bus.rsp_ready = 1'b0;
    ram_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA5A5_0000 | 32'(i);

    // Reset state, with a pending request that must not strobe
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b1, 3, 32'h1111_2222);
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_cen", 64'(ram_cen), 64'd1);
    check("rst_wen", 64'(ram_wen), 64'd1);
`ifdef SP_RAM_CLR_ON_RST_EN
    check("rst_init_busy", 64'(init_busy), 64'd1);
`else
    check("rst_init_busy", 64'(init_busy), 64'd0);
`endif
    drive(1'b0, 1'b0, 0, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef SP_RAM_CLR_ON_RST_EN
    // Clear sweep: one zero write per cycle, addresses 0..63, requests blocked
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("init_busy", 64'(init_busy), 64'd1);
      check("init_cen", 64'(ram_cen), 64'd0);
      check("init_wen", 64'(ram_wen), 64'd0);
      check("init_addr", 64'(ram_addr), 64'(i));
      check("init_wdata", 64'(ram_wdata), 64'd0);
      check("init_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      #1;
    end
`endif
    check("run_init_busy", 64'(init_busy), 64'd0);
    check("run_ready", 64'(bus.req_ready), 64'd1);
    check("run_cen_idle", 64'(ram_cen), 64'd1);

    // Write DEADBEEF to 5 then read 5
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
    #1;
    check("wr5_ready", 64'(bus.req_ready), 64'd1);
    check("wr5_cen", 64'(ram_cen), 64'd0);
    check("wr5_wen", 64'(ram_wen), 64'd0);
    check("wr5_addr", 64'(ram_addr), 64'd5);
    check("wr5_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 1'b0, 5, 32'h0);
    #1;
    check("rd5_cen", 64'(ram_cen), 64'd0);
    check("rd5_wen", 64'(ram_wen), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 32'h0);
    #1;
    check("rd5_lat1_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    check("rd5_lat2_valid", 64'(bus.rsp_valid), 64'd1);
    check("rd5_data", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("rd5_drained", 64'(bus.rsp_valid), 64'd0);

    // Fill mem[a] = a*3, then stream all reads back-to-back
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, i, 32'(i * 3));
      #1;
      check("fill_ready", 64'(bus.req_ready), 64'd1);
    end
    for (int c = 0; c < int'(DEPTH) + 2; c++) begin
      @(negedge clk);
      if (c < int'(DEPTH)) drive(1'b1, 1'b0, c, 32'h0);
      else                 drive(1'b0, 1'b0, 0, 32'h0);
      #1;
      if (c < int'(DEPTH)) check("stream_ready", 64'(bus.req_ready), 64'd1);
      if (c >= 2) begin
        check("stream_valid", 64'(bus.rsp_valid), 64'd1);
        check("stream_data", 64'(bus.rsp_rdata), 64'((c - 2) * 3));
      end
    end
    @(negedge clk);
    #1;
    check("stream_end_valid", 64'(bus.rsp_valid), 64'd0);

    // Backpressure: rsp_ready=0, four reads of addrs 0..3 (data 0,3,6,9)
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 0, 32'h0);
    #1;
    check("bp_c0_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1, 32'h0);
    #1;
    check("bp_c1_ready", 64'(bus.req_ready), 64'd1);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2, 32'h0);
      #1;
      check("bp_stall_ready", 64'(bus.req_ready), 64'd0);
      check("bp_stall_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_stall_data", 64'(bus.rsp_rdata), 64'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_c5_ready", 64'(bus.req_ready), 64'd1);
    check("bp_c5_data", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 3, 32'h0);
    #1;
    check("bp_c6_ready", 64'(bus.req_ready), 64'd1);
    check("bp_c6_data", 64'(bus.rsp_rdata), 64'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 32'h0);
    #1;
    check("bp_c7_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_c7_data", 64'(bus.rsp_rdata), 64'd6);
    @(negedge clk);
    #1;
    check("bp_c8_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_c8_data", 64'(bus.rsp_rdata), 64'd9);
    @(negedge clk);
    #1;
    check("bp_c9_valid", 64'(bus.rsp_valid), 64'd0);

    // Reset one cycle after a read fire
    @(negedge clk);
    drive(1'b1, 1'b0, 7, 32'h0);
    #1;
    check("rr_fire_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rr_rst_cen", 64'(ram_cen), 64'd1);
    check("rr_rst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("rr_rst2_valid", 64'(bus.rsp_valid), 64'd0);
    check("rr_rst2_cen", 64'(ram_cen), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rr_no_stale", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
    end
`ifdef SP_RAM_CLR_ON_RST_EN
    begin
      int guard = 0;
      while (init_busy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      #1;
      check("rr_init_done", 64'(init_busy), 64'd0);
    end
    // Cleared RAM reads back zero at the top address
    @(negedge clk);
    drive(1'b1, 1'b0, 63, 32'h0);
    #1;
    check("clr63_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 32'h0);
    @(negedge clk);
    #1;
    check("clr63_valid", 64'(bus.rsp_valid), 64'd1);
    check("clr63_data", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);
`endif

    // Write then read addr 10, consumer stalls 3 cycles
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 10, 32'h1234_5678);
    #1;
    check("wr10_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 10, 32'h0);
    #1;
    check("rd10_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("hold10_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold10_data", 64'(bus.rsp_rdata), 64'h1234_5678);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("pop10_valid", 64'(bus.rsp_valid), 64'd1);
    check("pop10_data", 64'(bus.rsp_rdata), 64'h1234_5678);
    @(negedge clk);
    #1;
    check("pop10_empty", 64'(bus.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
